// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB register block: register offsets,
// ERR bit positions and the rx-capture state encoding.
package uart_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h08;
  localparam logic [4:0] ADDR_ERR    = 5'h0C;
  localparam logic [4:0] ADDR_IRQ_EN = 5'h10;

  // Word index used for decode; byte lanes [1:0] carry no meaning here.
  localparam logic [2:0] WIDX_TXDATA = ADDR_TXDATA[4:2];
  localparam logic [2:0] WIDX_RXDATA = ADDR_RXDATA[4:2];
  localparam logic [2:0] WIDX_STATUS = ADDR_STATUS[4:2];
  localparam logic [2:0] WIDX_ERR    = ADDR_ERR[4:2];
  localparam logic [2:0] WIDX_IRQ_EN = ADDR_IRQ_EN[4:2];

  localparam int ERR_W       = 5;
  localparam int ERR_PARITY  = 0;
  localparam int ERR_STOP    = 1;
  localparam int ERR_BREAK   = 2;
  localparam int ERR_OVERFLW = 3;
  localparam int ERR_OVERRUN = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } rx_state_t;

endpackage

// File: rtl/uart_apb_if_if.sv
// APB3 slave bus bundle for the UART register block.
interface uart_apb_if_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for slow level signals coming from the sample_clk domain.
module uart_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_apb_if.sv
// APB register front end for the UART: TX/RX FIFO access, sticky errors, irq.
//   state    | meaning
//   ST_IDLE  | waiting for a synchronized rx_done rising edge
//   ST_CHECK | frame captured, waiting for synchronized rx_done to fall
module uart_apb_if
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_apb_if_if.slave         apb,
  output logic [DATA_SIZE-1:0] tx_wdata,
  output logic                 tx_write,
  input  logic                 tx_full,
  input  logic                 tx_empty,
  input  logic [DATA_SIZE-1:0] rx_rdata,
  output logic                 rx_read,
  input  logic                 rx_full,
  input  logic                 rx_empty,
  output logic                 rx_fifo_write,
  input  logic                 rx_done,
  input  logic                 parity_error,
  input  logic                 stop_error,
  input  logic                 break_error,
  input  logic                 overflow_error,
  output logic                 irq
);

  rx_state_t        r_state;
  logic             r_rx_fifo_write;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] r_irq_en;
  logic             r_irq;

  logic [4:0]       w_sync;
  logic             w_access;
  logic             w_capture;
  logic [31:0]      w_prdata;
  logic             w_pslverr;
  logic             w_tx_write;
  logic             w_rx_read;
  logic [ERR_W-1:0] w_err_clr;
  logic [ERR_W-1:0] w_err_set;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_irq_en_we;
  logic [ERR_W-1:0] w_irq_en_nxt;
  logic             w_unused;

  uart_sync2 #(.WIDTH(5)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({overflow_error, break_error, stop_error, parity_error, rx_done}),
    .o_q     (w_sync)
  );

  // Gating with reset_n forces the strobes and read data low the moment reset hits.
  assign w_access = apb.psel & apb.penable & reset_n;

  always_comb begin
    w_prdata    = '0;
    w_pslverr   = 1'b0;
    w_tx_write  = 1'b0;
    w_rx_read   = 1'b0;
    w_err_clr   = '0;
    w_irq_en_we = 1'b0;
    if (w_access) begin
      case (apb.paddr[4:2])
        WIDX_TXDATA: begin
          if (apb.pwrite && !tx_full) w_tx_write = 1'b1;
          else                        w_pslverr  = 1'b1;
        end
        WIDX_RXDATA: begin
          if (!apb.pwrite && !rx_empty) begin
            w_rx_read = 1'b1;
            w_prdata  = {{(32-DATA_SIZE){1'b0}}, rx_rdata};
          end else begin
            w_pslverr = 1'b1;
          end
        end
        WIDX_STATUS: begin
          if (apb.pwrite) w_pslverr = 1'b1;
          else            w_prdata  = {27'b0, rx_full, rx_empty, tx_full, tx_empty, 1'b0};
        end
        WIDX_ERR: begin
          if (apb.pwrite) w_err_clr = apb.pwdata[ERR_W-1:0];
          else            w_prdata  = {27'b0, r_err};
        end
        WIDX_IRQ_EN: begin
          if (apb.pwrite) w_irq_en_we = 1'b1;
          else            w_prdata    = {27'b0, r_irq_en};
        end
        default: w_pslverr = 1'b1;
      endcase
    end
  end

  assign w_capture = (r_state == ST_IDLE) && w_sync[0];

  always_comb begin
    w_err_set = '0;
    if (w_capture) begin
      w_err_set[ERR_PARITY]  = w_sync[1];
      w_err_set[ERR_STOP]    = w_sync[2];
      w_err_set[ERR_BREAK]   = w_sync[3];
      w_err_set[ERR_OVERFLW] = w_sync[4];
      w_err_set[ERR_OVERRUN] = rx_full;
    end
  end

  // Set is OR-ed in after the W1C mask so a coincident event is never lost.
  assign w_err_nxt    = (r_err & ~w_err_clr) | w_err_set;
  assign w_irq_en_nxt = w_irq_en_we ? apb.pwdata[ERR_W-1:0] : r_irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_rx_fifo_write <= 1'b0;
    end else begin
      r_rx_fifo_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync[0]) begin
            r_state         <= ST_CHECK;
            r_rx_fifo_write <= !rx_full;
          end
        end
        ST_CHECK: begin
          if (!w_sync[0]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err    <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_err    <= w_err_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= |(w_err_nxt & w_irq_en_nxt);
    end
  end

  assign apb.prdata    = w_prdata;
  assign apb.pready    = 1'b1;
  assign apb.pslverr   = w_pslverr;
  assign tx_wdata      = apb.pwdata[DATA_SIZE-1:0];
  assign tx_write      = w_tx_write;
  assign rx_read       = w_rx_read;
  assign rx_fifo_write = r_rx_fifo_write;
  assign irq           = r_irq;

  assign w_unused = ^{apb.pwdata[31:DATA_SIZE], apb.paddr[1:0], tx_empty};

endmodule

// File: tb/tb_uart_apb_if.sv
// Scoreboard bench for uart_apb_if: APB responses and rx pushes are queued at
// issue time and checked by an independent negedge monitor.
module tb_uart_apb_if;

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_wdata;
  logic       tx_write;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] rx_rdata;
  logic       rx_read;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_fifo_write;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;
  logic       break_error;
  logic       overflow_error;
  logic       irq;

  uart_apb_if_if bus ();

  uart_apb_if #(.DATA_SIZE(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .apb            (bus.slave),
    .tx_wdata       (tx_wdata),
    .tx_write       (tx_write),
    .tx_full        (tx_full),
    .tx_empty       (tx_empty),
    .rx_rdata       (rx_rdata),
    .rx_read        (rx_read),
    .rx_full        (rx_full),
    .rx_empty       (rx_empty),
    .rx_fifo_write  (rx_fifo_write),
    .rx_done        (rx_done),
    .parity_error   (parity_error),
    .stop_error     (stop_error),
    .break_error    (break_error),
    .overflow_error (overflow_error),
    .irq            (irq)
  );

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    logic        txw;
    logic [7:0]  txd;
    logic        rxr;
  } exp_t;

  exp_t       exp_q[$];
  int         push_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         mon_en = 1'b1;
  logic [4:0] m_err    = '0;
  logic [4:0] m_irq_en = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference response of the register block to one access, from the register map.
  function automatic exp_t model(input bit wr, input logic [4:0] addr, input logic [31:0] wd);
    exp_t e;
    int   off;
    e.prdata = '0; e.slverr = 1'b0; e.txw = 1'b0; e.txd = '0; e.rxr = 1'b0;
    off = int'(addr) & 'h1C;
    case (off)
      'h00: if (wr && !tx_full) begin e.txw = 1'b1; e.txd = wd[7:0]; end
            else e.slverr = 1'b1;
      'h04: if (!wr && !rx_empty) begin e.rxr = 1'b1; e.prdata = 32'(rx_rdata); end
            else e.slverr = 1'b1;
      'h08: if (wr) e.slverr = 1'b1;
            else e.prdata = 32'(int'(rx_full) * 16 + int'(rx_empty) * 8 + int'(tx_full) * 4 + int'(tx_empty) * 2);
      'h0C: if (!wr) e.prdata = 32'(m_err);
      'h10: if (!wr) e.prdata = 32'(m_irq_en);
      default: e.slverr = 1'b1;
    endcase
    return e;
  endfunction

  task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] wd);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    exp_q.push_back(model(wr, addr, wd));
    @(posedge clk);
    if (wr && (addr[4:2] == 3'd3)) m_err = m_err & ~wd[4:0];
    if (wr && (addr[4:2] == 3'd4)) m_irq_en = wd[4:0];
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic rx_frame(input logic [3:0] errs, input bit full, input int hold);
    rx_full = full;
    {overflow_error, break_error, stop_error, parity_error} = errs;
    rx_done = 1'b1;
    if (!full) push_q.push_back(cyc + 3);
    m_err = m_err | {full, errs};
    repeat (hold) @(posedge clk);
    #1;
    rx_done = 1'b0;
    {overflow_error, break_error, stop_error, parity_error} = 4'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_full = 1'b0;
  endtask

  task automatic check_irq(input string name);
    check(name, 32'(irq), 32'(|(m_err & m_irq_en)));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (bus.psel && bus.penable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("prdata",   bus.prdata,        e.prdata);
          check("pslverr",  32'(bus.pslverr),  32'(e.slverr));
          check("tx_write", 32'(tx_write),     32'(e.txw));
          check("rx_read",  32'(rx_read),      32'(e.rxr));
          if (e.txw) check("tx_wdata", 32'(tx_wdata), 32'(e.txd));
        end
      end else begin
        check("idle_prdata",  bus.prdata, 32'(0));
        check("idle_strobes", 32'({tx_write, rx_read, bus.pslverr}), 32'(0));
      end
      if (push_q.size() != 0 && push_q[0] == cyc) begin
        check("rx_fifo_write", 32'(rx_fifo_write), 32'(1));
        void'(push_q.pop_front());
      end else begin
        check("rx_fifo_write_idle", 32'(rx_fifo_write), 32'(0));
      end
    end
  end

  initial begin
    #500us;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  addr;
    logic [31:0] wd;
    reset_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    tx_full = 1'b0; tx_empty = 1'b1; rx_full = 1'b0; rx_empty = 1'b1; rx_rdata = '0;
    rx_done = 1'b0; parity_error = 1'b0; stop_error = 1'b0; break_error = 1'b0; overflow_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq", 32'(irq), 32'(0));
    check("reset_outs", 32'({tx_write, rx_read, rx_fifo_write, bus.pslverr}), 32'(0));
    check("reset_prdata", bus.prdata, 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    apb_xfer(1'b0, 5'h0C, 0);
    apb_xfer(1'b0, 5'h10, 0);
    check_irq("irq_after_reset");

    tx_empty = 1'b0;
    apb_xfer(1'b1, 5'h00, 32'hFFFF_FFB3);
    apb_xfer(1'b1, 5'h00, 32'h0000_005C);
    tx_full = 1'b1;
    apb_xfer(1'b1, 5'h00, 32'h0000_00AE);
    tx_full = 1'b0;

    rx_empty = 1'b1; rx_rdata = 8'h5C;
    apb_xfer(1'b0, 5'h04, 0);
    rx_empty = 1'b0;
    apb_xfer(1'b0, 5'h04, 0);
    rx_empty = 1'b1;

    rx_frame(4'b0000, 1'b0, 200);
    check_irq("irq_clean_frame");

    rx_frame(4'b0001, 1'b1, 6);
    apb_xfer(1'b0, 5'h0C, 0);
    check_irq("irq_err_masked");
    apb_xfer(1'b1, 5'h10, 32'h1);
    check_irq("irq_err_enabled");
    apb_xfer(1'b1, 5'h0C, 32'h1);
    apb_xfer(1'b0, 5'h0C, 0);
    check_irq("irq_after_w1c");

    apb_xfer(1'b1, 5'h04, 32'h12);
    apb_xfer(1'b1, 5'h08, 32'h12);
    apb_xfer(1'b0, 5'h00, 0);
    apb_xfer(1'b0, 5'h14, 0);
    apb_xfer(1'b1, 5'h1F, 32'hFF);
    apb_xfer(1'b0, 5'h13, 0);

    for (int i = 0; i < 80; i++) begin
      tx_full  = 1'($urandom);
      tx_empty = 1'($urandom);
      rx_full  = 1'($urandom);
      rx_empty = 1'($urandom);
      rx_rdata = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        rx_frame(4'($urandom), 1'($urandom), $urandom_range(3, 8));
      end else begin
        addr = 5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
        wd   = $urandom;
        apb_xfer(1'($urandom), addr, wd);
      end
      check_irq("irq_random");
    end
    tx_full = 1'b0; rx_full = 1'b0; rx_empty = 1'b1;

    // Clear racing a capture on the same edge: the capture must survive.
    apb_xfer(1'b1, 5'h0C, 32'h1F);
    rx_full = 1'b0; parity_error = 1'b1; rx_done = 1'b1;
    push_q.push_back(cyc + 3);
    @(posedge clk); #1;
    apb_xfer(1'b1, 5'h0C, 32'h1);
    m_err = m_err | 5'h01;
    repeat (3) @(posedge clk);
    #1;
    rx_done = 1'b0; parity_error = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    apb_xfer(1'b0, 5'h0C, 0);
    apb_xfer(1'b1, 5'h10, 32'h1F);
    check_irq("irq_before_reset");

    mon_en = 1'b0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 5'h00; bus.pwdata = 32'h77;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #2;
    check("tx_write_pre_reset", 32'(tx_write), 32'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_mid_access_outs", 32'({tx_write, rx_read, rx_fifo_write, bus.pslverr, irq}), 32'(0));
    check("reset_mid_access_prdata", bus.prdata, 32'(0));
    bus.psel = 1'b0; bus.penable = 1'b0;
    m_err = '0; m_irq_en = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    rx_done = 1'b1; rx_full = 1'b0;
    push_q.push_back(cyc + 3);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0; rx_done = 1'b0;
    #1;
    check("reset_in_check_outs", 32'({rx_fifo_write, irq, tx_write, rx_read}), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    rx_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0; rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    apb_xfer(1'b0, 5'h0C, 0);
    rx_frame(4'b0100, 1'b0, 5);
    apb_xfer(1'b0, 5'h0C, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("push_queue_drained", 32'(push_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
